// File: rtl/store_buffer_dmem.sv
// store_buffer_dmem: word-addressed data memory with a small circular store
// buffer in front of a single-ported array. Stores are queued and drained one
// per cycle whenever the array is not being read.
//
// Build option: define SB_FORWARD_EN to forward buffered store data to loads.
// Without it, a load that hits a buffered word stalls while the head drains.
module store_buffer_dmem #(
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [31:0]                 i_DM_addr,
    input  logic [31:0]                 i_DM_wd,
    input  logic                        i_DM_wen,
    input  logic                        i_DM_ren,
    output logic [31:0]                 o_DM_rd,
    output logic                        o_stall,
    output logic [$clog2(SB_DEPTH):0]   o_sb_count,
    output logic                        o_sb_empty
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    // Buffer bookkeeping (reset) and payload (not reset)
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [SB_DEPTH-1:0] r_valid;
    logic [AW-1:0]  r_idx  [SB_DEPTH];
    logic [31:0]    r_data [SB_DEPTH];

    // Data array; contents survive reset
    logic [31:0]    r_mem  [MEM_WORDS];

    logic [AW-1:0]  w_idx;
    logic           w_full;
    logic           w_match;
    logic           w_hazard;
    logic           w_enq;
    logic           w_drain;
    logic [31:0]    w_rd;
`ifdef SB_FORWARD_EN
    logic [31:0]    w_fwd_data;
`endif

    // Upper address bits alias onto the array
    assign w_idx  = i_DM_addr[AW+1:2];
    assign w_full = (r_count == CW'(SB_DEPTH));

    // Associative lookup, oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] slot;
        w_match = 1'b0;
`ifdef SB_FORWARD_EN
        w_fwd_data = 32'h0000_0000;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = r_head + PW'(i);
            if (r_valid[slot] && (r_idx[slot] == w_idx)) begin
                w_match = 1'b1;
`ifdef SB_FORWARD_EN
                w_fwd_data = r_data[slot];
`endif
            end else begin
                w_match = w_match;
            end
        end
    end

    // Request arbitration: stall, enqueue, drain and load data selection
    always_comb begin
`ifdef SB_FORWARD_EN
        w_hazard = 1'b0;
        if (w_match) begin
            w_rd = w_fwd_data;
        end else begin
            w_rd = r_mem[w_idx];
        end
`else
        // A load hitting a pending store waits; the array port is handed to
        // the drain so the hazard clears without requester help.
        w_hazard = i_DM_ren && w_match;
        w_rd     = r_mem[w_idx];
`endif
        // A full buffer refuses the store even if the head drains this cycle
        w_enq   = i_DM_wen && !w_full && !w_hazard;
        w_drain = (r_count != CW'(0)) && (!i_DM_ren || w_hazard);
    end

    // Pointer, occupancy and valid-bit state; cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end else begin
                r_head <= r_head;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end else begin
                r_tail <= r_tail;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload capture at the tail
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_idx[r_tail]  <= w_idx;
            r_data[r_tail] <= i_DM_wd;
        end else begin
            r_idx[r_tail]  <= r_idx[r_tail];
        end
    end

    // Array write from the buffer head; count is zero under reset so no write
    always_ff @(posedge i_clk) begin
        if (w_drain) begin
            r_mem[r_idx[r_head]] <= r_data[r_head];
        end else begin
            r_mem[r_idx[r_head]] <= r_mem[r_idx[r_head]];
        end
    end

    assign o_DM_rd    = w_rd;
    assign o_stall    = (i_DM_wen && w_full) || w_hazard;
    assign o_sb_count = r_count;
    assign o_sb_empty = (r_count == CW'(0));

endmodule

// File: tb/tb_store_buffer_dmem.sv
// Bench for store_buffer_dmem: a queue-based model checked every cycle, plus
// directed scenarios with literal expectations. Honors SB_FORWARD_EN.
module tb_store_buffer_dmem;

    localparam int MEM_WORDS = 1024;
    localparam int SB_DEPTH  = 4;
    localparam int AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0FF0;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_DM_addr;
    logic [31:0] i_DM_wd;
    logic        i_DM_wen;
    logic        i_DM_ren;
    logic [31:0] o_DM_rd;
    logic        o_stall;
    logic [$clog2(SB_DEPTH):0] o_sb_count;
    logic        o_sb_empty;

    always #5 i_clk = ~i_clk;

    store_buffer_dmem #(.MEM_WORDS(MEM_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_DM_addr(i_DM_addr), .i_DM_wd(i_DM_wd),
        .i_DM_wen(i_DM_wen), .i_DM_ren(i_DM_ren), .o_DM_rd(o_DM_rd),
        .o_stall(o_stall), .o_sb_count(o_sb_count), .o_sb_empty(o_sb_empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of pending stores plus the array contents written so far
    typedef struct { logic [AW-1:0] idx; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    logic [31:0] mmem[int];

    initial begin : compare
        logic [AW-1:0] widx;
        logic [31:0]   fwd;
        logic          match, hazard, enq, drain;
        ent_t          e;
        forever begin
            @(negedge i_clk);
            widx  = i_DM_addr[AW+1:2];
            enq   = 1'b0;
            drain = 1'b0;
            if (!i_rstn) begin
                mq.delete();
                chk("m_rst_count", 32'(o_sb_count), 32'd0);
                chk("m_rst_empty", 32'(o_sb_empty), 32'd1);
                chk("m_rst_stall", 32'(o_stall), 32'd0);
                if (mmem.exists(int'(widx))) chk("m_rst_rd", o_DM_rd, mmem[int'(widx)]);
            end else begin
                match = 1'b0;
                fwd   = 32'h0;
                foreach (mq[k]) begin
                    if (mq[k].idx == widx) begin
                        match = 1'b1;
                        fwd   = mq[k].data;
                    end
                end
`ifdef SB_FORWARD_EN
                hazard = 1'b0;
                if (match) chk("m_fwd_rd", o_DM_rd, fwd);
                else if (mmem.exists(int'(widx))) chk("m_rd", o_DM_rd, mmem[int'(widx)]);
`else
                hazard = i_DM_ren && match;
                if (!match && mmem.exists(int'(widx))) chk("m_rd", o_DM_rd, mmem[int'(widx)]);
`endif
                chk("m_stall", 32'(o_stall),
                    32'((i_DM_wen && mq.size() == SB_DEPTH) || hazard));
                chk("m_count", 32'(o_sb_count), 32'(mq.size()));
                chk("m_empty", 32'(o_sb_empty), 32'(mq.size() == 0));
                enq   = i_DM_wen && (mq.size() < SB_DEPTH) && !hazard;
                drain = (mq.size() > 0) && (!i_DM_ren || hazard);
                e.idx  = widx;
                e.data = i_DM_wd;
            end
            @(posedge i_clk);
            if (i_rstn) begin
                if (drain) begin
                    mmem[int'(mq[0].idx)] = mq[0].data;
                    void'(mq.pop_front());
                end
                if (enq) mq.push_back(e);
            end
        end
    end

    task automatic step(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] wd);
        @(posedge i_clk);
        #1;
        i_DM_wen  = wen;
        i_DM_ren  = ren;
        i_DM_addr = addr;
        i_DM_wd   = wd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, IDLE_ADDR, 32'h0);
    endtask

    task automatic load_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        step(1'b0, 1'b1, addr, 32'h0);
        @(negedge i_clk);
        chk(name, o_DM_rd, exp);
    endtask

    initial begin : stim
        i_rstn = 1'b0; i_DM_wen = 1'b0; i_DM_ren = 1'b0;
        i_DM_addr = IDLE_ADDR; i_DM_wd = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_count", 32'(o_sb_count), 32'd0);
        chk("reset_empty", 32'(o_sb_empty), 32'd1);
        chk("reset_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk); #1; i_rstn = 1'b1;

        // Store then immediate load of the same word
        step(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h10, 32'h0);
        @(negedge i_clk);
`ifdef SB_FORWARD_EN
        chk("fwd_deadbeef", o_DM_rd, 32'hDEAD_BEEF);
        chk("fwd_nostall", 32'(o_stall), 32'd0);
`else
        chk("hazard_stall", 32'(o_stall), 32'd1);
`endif
        step(1'b0, 1'b1, 32'h10, 32'h0);
        @(negedge i_clk);
        chk("load_deadbeef", o_DM_rd, 32'hDEAD_BEEF);
        chk("load_nostall", 32'(o_stall), 32'd0);
        idle(3);

        // Same-cycle store and load: old array value, count 1 afterwards
        step(1'b1, 1'b0, 32'h40, 32'h1111_0040);
        idle(2);
        step(1'b1, 1'b1, 32'h40, 32'hCAFE_0040);
        @(negedge i_clk);
        chk("same_cycle_old", o_DM_rd, 32'h1111_0040);
        idle(1);
        @(negedge i_clk);
        chk("same_cycle_count", 32'(o_sb_count), 32'd1);
        idle(2);
        load_chk("load_40_new", 32'h40, 32'hCAFE_0040);

        // Two stores to one word: youngest wins
`ifdef SB_FORWARD_EN
        step(1'b1, 1'b1, 32'h20, 32'h1);
        step(1'b1, 1'b1, 32'h20, 32'h2);
        step(1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge i_clk);
        chk("youngest_fwd", o_DM_rd, 32'h2);
        chk("youngest_count", 32'(o_sb_count), 32'd2);
`else
        step(1'b1, 1'b0, 32'h20, 32'h1);
        step(1'b1, 1'b0, 32'h20, 32'h2);
        step(1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge i_clk);
        chk("youngest_hazard", 32'(o_stall), 32'd1);
`endif
        idle(4);
        load_chk("youngest_array", 32'h20, 32'h2);

        // Fill with loads holding the array: fifth store stalls
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
        idle(4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i));
        step(1'b1, 1'b1, 32'h110, 32'hB000_0004);
        @(negedge i_clk);
        chk("full_count", 32'(o_sb_count), 32'd4);
        chk("full_stall", 32'(o_stall), 32'd1);
        load_chk("full_array_unchanged", 32'h110, 32'hA000_0004);
        idle(5);
        load_chk("full_drained_100", 32'h100, 32'hB000_0000);
        load_chk("full_not_written_110", 32'h110, 32'hA000_0004);

        // Three buffered stores then drain 3,2,1,0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(4*i), 32'h3000_0000 + 32'(i));
        for (int i = 3; i >= 0; i--) begin
            idle(1);
            @(negedge i_clk);
            chk("drain_count", 32'(o_sb_count), 32'(i));
        end
        chk("drain_empty", 32'(o_sb_empty), 32'd1);
        for (int i = 0; i < 3; i++) load_chk("drain_word", 32'(4*i), 32'h3000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h30 + 32'(4*i), 32'h5000_0000 + 32'(i));
        idle(3);
        load_chk("wrap_first", 32'h30, 32'h5000_0000);
        load_chk("wrap_last", 32'h44, 32'h5000_0005);

        // Reset with three pending stores discards them
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(4*i), 32'h4000_0000 + 32'(i));
        @(posedge i_clk); #1;
        chk("pre_reset_count", 32'(o_sb_count), 32'd3);
        i_rstn = 1'b0; i_DM_wen = 1'b0; i_DM_ren = 1'b0;
        #1;
        chk("async_reset_count", 32'(o_sb_count), 32'd0);
        chk("async_reset_empty", 32'(o_sb_empty), 32'd1);
        repeat (2) @(posedge i_clk);
        #1; i_rstn = 1'b1;
        for (int i = 0; i < 3; i++) load_chk("post_reset_old", 32'(4*i), 32'h3000_0000 + 32'(i));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer_dmem.md
STORE_BUFFER_DMEM -- requirements
Module: store_buffer_dmem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning data array depth in 32-bit words (power of two).
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of two, >=2).
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_DM_addr, input, addr_t (32 bits): byte address from the core; bits [1:0] ignored.
REQ-006 SHALL have port i_DM_wd, input, data_t (32 bits): store data.
REQ-007 SHALL have port i_DM_wen, input, 1 bit: store request this cycle.
REQ-008 SHALL have port i_DM_ren, input, 1 bit: load request this cycle.
REQ-009 SHALL have port o_DM_rd, output, data_t (32 bits): load data, combinational from the current-cycle address.
REQ-010 SHALL have port o_stall, output, 1 bit: request not serviced this cycle; requester holds and retries.
REQ-011 SHALL have port o_sb_count, output, clog2(SB_DEPTH)+1 bits: occupied store-buffer entries.
REQ-012 SHALL have port o_sb_empty, output, 1 bit: o_sb_count==0.

Function
REQ-013 SHALL index the array and compare entries with word index = addr[clog2(MEM_WORDS)+1:2]; upper bits are ignored (aliasing).
REQ-014 SHALL keep stores in a circular FIFO with head pointer, tail pointer and count; each entry holds {valid, word index, data}.
REQ-015 SHALL enqueue at tail on the clock edge when i_DM_wen=1 and count<SB_DEPTH; the tail wraps from SB_DEPTH-1 to 0.
REQ-016 SHALL assert o_stall combinationally when i_DM_wen=1 and count==SB_DEPTH; the store is not enqueued, even if a drain occurs in the same cycle.
REQ-017 SHALL drain exactly one head entry into the array per cycle when count>0 and i_DM_ren=0; the head wraps like the tail.
REQ-018 SHALL block draining while i_DM_ren=1, because the array is single-ported; the exception is REQ-026.
REQ-019 SHALL leave count unchanged on a simultaneous enqueue and drain, increment it on enqueue only, and decrement it on drain only.
REQ-020 SHALL drive o_DM_rd from the youngest valid entry whose index matches; with no match it drives array[index].
REQ-021 SHALL NOT forward a store enqueued in the same cycle to a load in that cycle; when both i_DM_wen and i_DM_ren are high, both proceed independently.
REQ-022 SHALL drive o_DM_rd from the array/buffer lookup regardless of i_DM_ren.

Reset
REQ-023 SHALL, while i_rstn=0, clear head, tail, count and all valid bits; the effect is immediate, not waiting for a clock edge.
REQ-024 SHALL drive outputs during reset as o_stall=0, o_sb_count=0, o_sb_empty=1, and o_DM_rd=array[index]; array contents are not reset.
REQ-025 SHALL discard pending stores when reset is asserted mid-operation; discarded stores never reach the array.

Configuration
REQ-026 SHALL support the macro SB_FORWARD_EN: when defined, loads use REQ-020 forwarding. When undefined, a load whose index matches any valid entry asserts o_stall, o_DM_rd is ignored by the requester, and the head drains that cycle despite i_DM_ren=1; loads with no match read the array directly.

Verification
REQ-027 SHALL cover: after reset, store 0xDEADBEEF to 0x10, then load 0x10 the next cycle -> o_DM_rd=0xDEADBEEF (forwarded with SB_FORWARD_EN; otherwise o_stall=1 for one cycle, then 0xDEADBEEF from the array).
REQ-028 SHALL cover: 5 back-to-back stores with i_DM_ren held at 1 and SB_DEPTH=4 -> o_sb_count reaches 4, 5th store gets o_stall=1, and the array is unchanged.
REQ-029 SHALL cover: stores of 0x1 and then 0x2 to 0x20, followed by an immediate load of 0x20 -> o_DM_rd=0x2 (youngest wins); after draining, the array holds 0x2.
REQ-030 SHALL cover: 3 stores, then 3 idle cycles -> o_sb_count goes 3,2,1,0, o_sb_empty=1, and array words 0,1,2 match in order; then 6 more stores with drains exercise pointer wrap with no loss.
REQ-031 SHALL cover: reset asserted while o_sb_count=3 -> count=0 immediately, and a load of those addresses returns the old array data.
REQ-032 SHALL cover: store and load of 0x40 in the same cycle with an empty buffer -> o_DM_rd is the old array value, and the next cycle o_sb_count=1.
